skin_sequencer: RTL and testbench

SKIN_SEQUENCER -- requirements
Module: skin_sequencer

---
 rtl/skin_sequencer.sv | 169 ++++++++++++++++
 tb/tb_skin_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/skin_sequencer.sv
// skin_sequencer
//   Chooses the sprite pose for the player character once per video frame.
//   A six-state FSM tracks idle / walking / charging a jump / airborne /
//   landing. Walking alternates the walk pose with the idle pose every
//   WALK_PERIOD frames, and the landing pose is held for LAND_HOLD frames
//   after touchdown. Everything advances only on frame_tick.
//
// Parameters
//   WALK_PERIOD    frames per walk-animation phase (1..255)
//   LAND_HOLD      frames the landing pose is held after touchdown (1..255)
//
// Ports
//   clk            system clock, rising-edge active
//   rst_n          asynchronous active-low reset
//   frame_tick     one-cycle strobe at start of vertical blank
//   on_ground      1 = standing on a platform
//   jump_hold      1 = jump key held
//   move_left      1 = left key held
//   move_right     1 = right key held
//   character_skin pose code: 0 idle, 1 prep/curled, 2 jump, 3 left, 4 right
//   skin_changed   one-cycle pulse when character_skin takes a new value
//   state_dbg      current FSM state encoding

`timescale 1ns/1ps

module skin_sequencer #(
    parameter int WALK_PERIOD = 8,
    parameter int LAND_HOLD   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       on_ground,
    input  logic       jump_hold,
    input  logic       move_left,
    input  logic       move_right,
    output logic [2:0] character_skin,
    output logic       skin_changed,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WALK_L = 3'd1,
        WALK_R = 3'd2,
        CHARGE = 3'd3,
        AIR    = 3'd4,
        LAND   = 3'd5
    } state_t;

    localparam logic [7:0] WALK_LAST = 8'(WALK_PERIOD - 1);
    localparam logic [7:0] LAND_LOAD = 8'(LAND_HOLD - 1);

    localparam logic [2:0] SKIN_IDLE  = 3'd0;
    localparam logic [2:0] SKIN_PREP  = 3'd1;
    localparam logic [2:0] SKIN_JUMP  = 3'd2;
    localparam logic [2:0] SKIN_LEFT  = 3'd3;
    localparam logic [2:0] SKIN_RIGHT = 3'd4;

    state_t     state_r,   state_nx;
    logic [7:0] walk_cnt,  walk_cnt_nx;
    logic       walk_phase, walk_phase_nx;
    logic [7:0] land_cnt,  land_cnt_nx;
    logic [2:0] skin_nx;
    logic       changed_nx;
    logic       state_legal;
    logic       walk_dir_ok;

    // Pose shown for a given state; walking shows idle during phase 1.
    function automatic logic [2:0] pose_of(input state_t s, input logic ph);
        logic [2:0] p;
        case (s)
            IDLE:    p = SKIN_IDLE;
            WALK_L:  p = ph ? SKIN_IDLE : SKIN_LEFT;
            WALK_R:  p = ph ? SKIN_IDLE : SKIN_RIGHT;
            CHARGE:  p = SKIN_PREP;
            AIR:     p = SKIN_JUMP;
            LAND:    p = SKIN_PREP;
            default: p = SKIN_IDLE;
        endcase
        return p;
    endfunction

    // Landing countdown stops at zero instead of wrapping.
    function automatic logic [7:0] sat_dec(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

    // State register and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            walk_cnt       <= 8'd0;
            walk_phase     <= 1'b0;
            land_cnt       <= 8'd0;
            character_skin <= SKIN_IDLE;
            skin_changed   <= 1'b0;
        end else begin
            state_r        <= state_nx;
            walk_cnt       <= walk_cnt_nx;
            walk_phase     <= walk_phase_nx;
            land_cnt       <= land_cnt_nx;
            character_skin <= skin_nx;
            skin_changed   <= changed_nx;
        end
    end

    always_comb begin
        case (state_r)
            IDLE, WALK_L, WALK_R, CHARGE, AIR, LAND: state_legal = 1'b1;
            default:                                 state_legal = 1'b0;
        endcase
    end

    // Left and right together cancel out.
    assign walk_dir_ok = move_left ^ move_right;

    // Next-state and output decode; between ticks everything holds and
    // only the change pulse drops.
    always_comb begin
        state_nx      = state_r;
        walk_cnt_nx   = walk_cnt;
        walk_phase_nx = walk_phase;
        land_cnt_nx   = land_cnt;
        skin_nx       = character_skin;
        changed_nx    = 1'b0;

        if (frame_tick) begin
            land_cnt_nx = 8'd0;
            if (!state_legal) begin
                state_nx = IDLE;
            end else if (!on_ground) begin
                state_nx = AIR;
            end else if (state_r == AIR) begin
                state_nx    = LAND;
                land_cnt_nx = LAND_LOAD;
            end else if (state_r == LAND && land_cnt != 8'd0) begin
                // Keys are ignored until the landing hold runs out.
                state_nx    = LAND;
                land_cnt_nx = sat_dec(land_cnt);
            end else if (jump_hold) begin
                state_nx = CHARGE;
            end else if (walk_dir_ok) begin
                state_nx = move_left ? WALK_L : WALK_R;
            end else begin
                state_nx = IDLE;
            end

            // Walk animation restarts on every entry, including L<->R swaps.
            if ((state_nx == WALK_L || state_nx == WALK_R) && state_nx == state_r) begin
                if (walk_cnt == WALK_LAST) begin
                    walk_cnt_nx   = 8'd0;
                    walk_phase_nx = ~walk_phase;
                end else begin
                    walk_cnt_nx   = walk_cnt + 8'd1;
                end
            end else begin
                walk_cnt_nx   = 8'd0;
                walk_phase_nx = 1'b0;
            end

            skin_nx    = pose_of(state_nx, walk_phase_nx);
            changed_nx = (skin_nx != character_skin);
        end
    end

    assign state_dbg = state_r;

endmodule

// File: tb/tb_skin_sequencer.sv
`timescale 1ns/1ps

module tb_skin_sequencer;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       on_ground;
    logic       jump_hold;
    logic       move_left;
    logic       move_right;
    logic [2:0] character_skin;
    logic       skin_changed;
    logic [2:0] state_dbg;

    int n_cmp;
    int n_err;

    skin_sequencer #(.WALK_PERIOD(8), .LAND_HOLD(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_tick     (frame_tick),
        .on_ground      (on_ground),
        .jump_hold      (jump_hold),
        .move_left      (move_left),
        .move_right     (move_right),
        .character_skin (character_skin),
        .skin_changed   (skin_changed),
        .state_dbg      (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse frame_tick across one rising edge; returns at the following
    // falling edge, where the new pose and any change pulse are visible.
    task automatic do_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic chk3(input string tag, input logic [2:0] skin, input logic chg, input logic [2:0] st);
        chk({tag, "_skin"}, {5'd0, character_skin}, {5'd0, skin});
        chk({tag, "_chg"},  {7'd0, skin_changed},   {7'd0, chg});
        chk({tag, "_st"},   {5'd0, state_dbg},      {5'd0, st});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        frame_tick = 1'b0;
        on_ground = 1'b1;
        jump_hold = 1'b0;
        move_left = 1'b0;
        move_right = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk3("reset", 3'd0, 1'b0, 3'd0);
        rst_n = 1'b1;
        // Nothing moves before the first tick, even with keys held.
        move_right = 1'b1;
        repeat (4) @(negedge clk);
        chk3("pre_tick", 3'd0, 1'b0, 3'd0);

        // Walk right, 20 ticks
        for (int i = 1; i <= 20; i++) begin
            do_tick();
            chk3($sformatf("walk_t%0d", i),
                 (i <= 8 || i >= 17) ? 3'd4 : 3'd0,
                 (i == 1 || i == 9 || i == 17),
                 3'd2);
        end
        @(negedge clk);
        chk("pulse_clears", {7'd0, skin_changed}, 8'd0);

        // Tick gating: inputs wiggle with no frame_tick
        for (int i = 0; i < 12; i++) begin
            on_ground  = i[0];
            jump_hold  = i[1];
            move_left  = i[2];
            move_right = ~i[0];
            @(negedge clk);
            chk3($sformatf("gate_%0d", i), 3'd4, 1'b0, 3'd2);
        end

        // Jump arc
        on_ground = 1'b1; move_left = 1'b0; move_right = 1'b0; jump_hold = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            do_tick();
            chk3($sformatf("charge_t%0d", i), 3'd1, i == 1, 3'd3);
        end
        jump_hold = 1'b0; on_ground = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            do_tick();
            chk3($sformatf("air_t%0d", i), 3'd2, i == 1, 3'd4);
        end
        on_ground = 1'b1; move_left = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            do_tick();
            chk3($sformatf("land_t%0d", i), 3'd1, i == 1, 3'd5);
        end
        do_tick();
        chk3("walkl_entry", 3'd3, 1'b1, 3'd1);

        // Direction swap on phase 1
        for (int i = 2; i <= 8; i++) begin
            do_tick();
            chk3($sformatf("walkl_t%0d", i), 3'd3, 1'b0, 3'd1);
        end
        do_tick();
        chk3("walkl_ph1", 3'd0, 1'b1, 3'd1);
        move_left = 1'b0; move_right = 1'b1;
        do_tick();
        chk3("swap_entry", 3'd4, 1'b1, 3'd2);
        for (int i = 2; i <= 8; i++) do_tick();
        chk3("swap_t8", 3'd4, 1'b0, 3'd2);
        do_tick();
        chk3("swap_t9", 3'd0, 1'b1, 3'd2);

        // Conflict and priority
        move_left = 1'b1; move_right = 1'b1;
        do_tick();
        chk3("conflict", 3'd0, 1'b0, 3'd0);
        jump_hold = 1'b1;
        do_tick();
        chk3("conf_jump", 3'd1, 1'b1, 3'd3);
        on_ground = 1'b0;
        do_tick();
        chk3("conf_air", 3'd2, 1'b1, 3'd4);

        // Async reset in LAND with land_cnt=3
        on_ground = 1'b1;
        do_tick();
        chk3("rl_t1", 3'd1, 1'b1, 3'd5);
        do_tick();
        do_tick();
        chk3("rl_t3", 3'd1, 1'b0, 3'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk3("async_rst", 3'd0, 1'b0, 3'd0);
        jump_hold = 1'b0; move_left = 1'b0; move_right = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk3("post_rst", 3'd0, 1'b0, 3'd0);
        do_tick();
        chk3("post_rst_tick", 3'd0, 1'b0, 3'd0);

        // LAND -> CHARGE keeps pose 1 with no pulse
        jump_hold = 1'b1;
        do_tick();
        chk3("lc_charge", 3'd1, 1'b1, 3'd3);
        on_ground = 1'b0;
        do_tick();
        chk3("lc_air", 3'd2, 1'b1, 3'd4);
        on_ground = 1'b1;
        for (int i = 1; i <= 6; i++) do_tick();
        chk3("lc_land6", 3'd1, 1'b0, 3'd5);
        do_tick();
        chk3("lc_recharge", 3'd1, 1'b0, 3'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
